priority_encoder_serial: RTL
============================

Name: priority_encoder_serial

Overview:
- Parametrised, registered successor to the fixed 32-input priority encoder.
- Accepts a WIDTH-bit request vector over a valid/ready handshake and latches it.
- Emits the index of every set bit, one per accepted output beat, in priority order (MSB-first or LSB-first, selected per vector), clearing each bit as it is served.
- Sits between request-collection logic and a downstream servicing unit that consumes one index at a time.

Parameters:
- WIDTH, 32, number of request lines; legal range 2..1024.
- IDX_W, $clog2(WIDTH), index width. Derived; must not be overridden.

Ports:
- clk  input  1  rising-edge clock, single clock domain.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  request vector valid.
- in_ready  output  1  block can accept a new vector this cycle.
- in_req  input  WIDTH  request vector; bit i = line i requesting.
- in_msb_first  input  1  1 = highest index served first, 0 = lowest first; sampled at accept.
- out_valid  output  1  out_idx holds a pending index.
- out_ready  input  1  downstream accepts current index.
- out_idx  output  IDX_W  index of currently selected request bit.
- out_last  output  1  current index is the final set bit of the vector.
- out_count  output  IDX_W+1  number of set bits still pending, including the current one.

Behaviour:
- Reset value of every output is 0, including in_ready.
  - While rst_n is low: pending register, direction flag and outputs are all 0.
  - The first cycle after rst_n deasserts: in_ready = 1.
- State is a pending register pend[WIDTH-1:0] plus a direction flag dir. The block is IDLE when pend == 0 and DRAIN otherwise.
- Input accept happens when in_valid && in_ready.
  - pend <= in_req and dir <= in_msb_first on the next edge.
  - Latency is 1 cycle: out_valid rises the cycle after accept when in_req != 0.
- in_ready = (pend == 0) || (out_valid && out_ready && out_last). This is combinational and allows back-to-back vectors with no bubble.
- Zero vector:
  - Accepted and discarded.
  - No output beat; block remains IDLE; in_ready stays 1.
- Output datapath is combinational from the registers:
  - out_valid = |pend.
  - out_idx = highest set bit of pend if dir = 1, else lowest set bit.
  - out_last = (popcount(pend) == 1).
  - out_count = popcount(pend).
  - When pend == 0: out_idx = 0, out_last = 0, out_count = 0.
- Output accept: on out_valid && out_ready, clear bit out_idx of pend on the next edge.
- When out_ready is low, out_idx, out_last and out_count are held stable and pend is unchanged. in_req changes do not affect a latched vector.
- Simultaneous last-beat accept and new input accept: pend <= in_req, and the new vector is served next cycle.
- A new vector is never merged with a partially drained one. in_ready is low during DRAIN except on the last beat.
- Full vector (all ones) produces WIDTH beats.
  - MSB-first order: WIDTH-1 down to 0.
  - LSB-first order: 0 up to WIDTH-1.
- Reset mid-drain: pending bits are dropped with no further beats, and outputs go to 0 asynchronously.
- Behaviour when in_req or out_ready is X is undefined; the bench must not drive it.

Test Plan:
- Reset, WIDTH=32: in_ready=0 during reset, 1 after release. Accept in_req=0x8000_0011, msb_first=1 → beats idx 31, 4, 0 (out_count 3, 2, 1; out_last on idx 0). in_ready low until the last beat.
- Same vector with msb_first=0 and out_ready held 1 → idx 0, 4, 31 on consecutive cycles. A second vector 0x0000_0002 presented during the last beat is accepted the same cycle and yields idx 1 next cycle with no bubble.
- Backpressure: in_req=0x0000_00C0, out_ready low for 5 cycles → out_idx=7 and out_count=2 stable all 5 cycles, then idx 7, 6 once out_ready is high.
- Zero vector: accept in_req=0 → out_valid stays 0 and in_ready stays 1. A following accept of 0x1 → idx 0 with out_last=1 one cycle later.
- All-ones, WIDTH=32, msb_first=1 → 32 beats 31..0, out_count 32..1; rerun with WIDTH=5 → 5 beats 4..0.
- Reset asserted mid-drain after 2 of 3 beats of 0x0000_0111 → outputs 0 immediately. After release, out_valid=0 and in_ready=1 with no stale beat.

Source files
------------

// File: rtl/priority_encoder_serial.sv
// priority_encoder_serial
//   Latches a WIDTH-bit request vector and emits the index of each set bit,
//   one per accepted output beat. Bits are served highest-first or
//   lowest-first, as chosen at accept, and each bit is cleared once served.
//
// Ports
//   clk, rst_n      rising-edge clock, asynchronous active-low reset
//   in_valid        request vector valid
//   in_ready        a new vector can be accepted this cycle
//   in_req          request vector, bit i = line i requesting
//   in_msb_first    1 = serve the highest index first, 0 = the lowest first
//   out_valid       out_idx holds a pending index
//   out_ready       downstream takes the current index
//   out_idx         index of the currently selected request bit
//   out_last        current index is the final pending bit
//   out_count       pending bits, including the current one
module priority_encoder_serial #(
   parameter int WIDTH = 32,
   parameter int IDX_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_req,
   input  logic             in_msb_first,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [IDX_W-1:0] out_idx,
   output logic             out_last,
   output logic [IDX_W:0]   out_count
);

   logic [WIDTH-1:0] pend, pend_nxt;
   logic             dir, dir_nxt;
   logic [IDX_W-1:0] hi_idx, lo_idx;
   logic [IDX_W:0]   cnt;
   logic             in_fire, out_fire;

   // Scan the pending bits once in each direction. The last hit wins, so
   // the upward scan leaves the highest set bit and the downward scan
   // leaves the lowest. An empty vector yields 0 for every output.
   always_comb begin
      hi_idx = '0;
      lo_idx = '0;
      cnt    = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (pend[i]) begin
            hi_idx = IDX_W'(i);
            cnt    = cnt + (IDX_W+1)'(1);
         end
      end
      for (int i = WIDTH-1; i >= 0; i--) begin
         if (pend[i]) lo_idx = IDX_W'(i);
      end
   end

   assign out_valid = |pend;
   assign out_idx   = dir ? hi_idx : lo_idx;
   assign out_count = cnt;
   assign out_last  = (cnt == (IDX_W+1)'(1));

   // A vector is accepted when the block is empty, or on the beat that
   // drains the last pending bit, so back-to-back vectors see no bubble.
   // Gating with rst_n holds in_ready low while reset is asserted.
   assign in_ready = rst_n & (~out_valid | (out_ready & out_last));

   assign in_fire  = in_valid & in_ready;
   assign out_fire = out_valid & out_ready;

   // A new vector replaces the register contents. This also covers the
   // last beat, where the served bit would have cleared pend to zero.
   always_comb begin
      pend_nxt = pend;
      dir_nxt  = dir;
      if (in_fire) begin
         pend_nxt = in_req;
         dir_nxt  = in_msb_first;
      end else if (out_fire) begin
         for (int i = 0; i < WIDTH; i++) begin
            if (IDX_W'(i) == out_idx) pend_nxt[i] = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend <= '0;
         dir  <= 1'b0;
      end else begin
         pend <= pend_nxt;
         dir  <= dir_nxt;
      end
   end

endmodule
